// File: rtl/tri_raster_stream_pkg.sv
// Shared types and defaults for the triangle rasterizer slice.
// Optional build macro: TRI_RASTER_CULL_EN (see tri_raster_stream.sv).
package tri_raster_stream_pkg;

  localparam int COORD_W_DEF  = 12;
  localparam int EDGE_W_DEF   = 2*COORD_W_DEF + 3;
  localparam int COLOUR_W_DEF = 32;
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  typedef logic signed [COORD_W_DEF-1:0] coord_t;
  typedef logic signed [EDGE_W_DEF-1:0]  edge_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP0 = 3'd1,
    ST_SETUP1 = 3'd2,
    ST_SCAN   = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/tri_raster_stream_stepper.sv
// One incremental edge function: row-start and current value.
// Priority: init, then hold, then row step, then x step.
module tri_edge_stepper
  import tri_raster_stream_pkg::*;
#(
  parameter int EDGE_W = EDGE_W_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_init,
  input  logic                     i_step_x,
  input  logic                     i_step_row,
  input  logic                     i_hold,
  input  logic signed [EDGE_W-1:0] i_init_val,
  input  logic signed [EDGE_W-1:0] i_dx,
  input  logic signed [EDGE_W-1:0] i_dy,
  output logic signed [EDGE_W-1:0] o_value
);

  logic signed [EDGE_W-1:0] row_reg;
  logic signed [EDGE_W-1:0] cur_reg;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      row_reg <= '0;
      cur_reg <= '0;
    end else if (i_init) begin
      row_reg <= i_init_val;
      cur_reg <= i_init_val;
    end else if (!i_hold) begin
      if (i_step_row) begin
        row_reg <= row_reg + i_dy;
        cur_reg <= row_reg + i_dy;
      end else if (i_step_x) begin
        cur_reg <= cur_reg + i_dx;
      end
    end
  end

  assign o_value = cur_reg;

endmodule

// File: rtl/tri_raster_stream.sv
// Bounding-box triangle rasterizer streaming covered pixels over valid/ready.
// Build macro TRI_RASTER_CULL_EN: when defined, clockwise (negative area) triangles are culled.
module tri_raster_stream
  import tri_raster_stream_pkg::*;
#(
  parameter int COORD_W  = COORD_W_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int COLOUR_W = COLOUR_W_DEF,
  parameter int EDGE_W   = 2*COORD_W + 3
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic signed [COORD_W-1:0]  i_x1,
  input  logic signed [COORD_W-1:0]  i_y1,
  input  logic signed [COORD_W-1:0]  i_x2,
  input  logic signed [COORD_W-1:0]  i_y2,
  input  logic signed [COORD_W-1:0]  i_x3,
  input  logic signed [COORD_W-1:0]  i_y3,
  input  logic [COLOUR_W-1:0]        i_colour,
  output logic                       o_idle,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic signed [COORD_W-1:0]  o_x,
  output logic signed [COORD_W-1:0]  o_y,
  output logic signed [EDGE_W-1:0]   o_w0,
  output logic signed [EDGE_W-1:0]   o_w1,
  output logic signed [EDGE_W-1:0]   o_w2,
  output logic signed [EDGE_W-1:0]   o_area,
  output logic [COLOUR_W-1:0]        o_colour,
  output logic                       o_done
);

  localparam logic signed [COORD_W-1:0] MAX_X = COORD_W'(SCREEN_W - 1);
  localparam logic signed [COORD_W-1:0] MAX_Y = COORD_W'(SCREEN_H - 1);

  state_e state_reg, state_next;

  logic signed [COORD_W-1:0] vx_reg [3];
  logic signed [COORD_W-1:0] vy_reg [3];
  logic [COLOUR_W-1:0]       colour_reg;
  logic                      neg_reg;
  logic signed [EDGE_W-1:0]  area_reg;
  logic signed [EDGE_W-1:0]  dx_reg [3];
  logic signed [EDGE_W-1:0]  dy_reg [3];
  logic signed [COORD_W-1:0] minx_reg, maxx_reg, miny_reg, maxy_reg;
  logic signed [COORD_W-1:0] x_reg, y_reg;

  logic signed [EDGE_W-1:0]  xe [3];
  logic signed [EDGE_W-1:0]  ye [3];
  logic signed [EDGE_W-1:0]  raw_dx [3];
  logic signed [EDGE_W-1:0]  raw_dy [3];
  logic signed [EDGE_W-1:0]  init_val [3];
  logic signed [EDGE_W-1:0]  cur_val [3];
  logic [2:0]                edge_pos;
  logic signed [EDGE_W-1:0]  area_raw;

  logic signed [COORD_W-1:0] raw_minx, raw_maxx, raw_miny, raw_maxy;
  logic signed [COORD_W-1:0] bb_minx, bb_maxx, bb_miny, bb_maxy;
  logic box_empty, area_zero, cull_tri;
  logic out_free, scan_go, row_end, last_cand, covered;

  // Edge i runs from vertex j=(i+1)%3 to k=(i+2)%3, so E_i = dEdy*(py-yj) + dEdx*(px-xj).
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
      localparam int J = (gi + 1) % 3;
      localparam int K = (gi + 2) % 3;

      assign xe[gi]       = EDGE_W'(vx_reg[gi]);
      assign ye[gi]       = EDGE_W'(vy_reg[gi]);
      assign raw_dx[gi]   = ye[J] - ye[K];
      assign raw_dy[gi]   = xe[K] - xe[J];
      assign init_val[gi] = dy_reg[gi] * (EDGE_W'(miny_reg) - ye[J])
                          + dx_reg[gi] * (EDGE_W'(minx_reg) - xe[J]);
      assign edge_pos[gi] = ~cur_val[gi][EDGE_W-1];

      tri_edge_stepper #(.EDGE_W(EDGE_W)) u_stepper (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_init     (state_reg == ST_SETUP1),
        .i_step_x   (!row_end),
        .i_step_row (row_end),
        .i_hold     (!scan_go),
        .i_init_val (init_val[gi]),
        .i_dx       (dx_reg[gi]),
        .i_dy       (dy_reg[gi]),
        .o_value    (cur_val[gi])
      );
    end
  endgenerate

  assign area_raw = raw_dy[0] * (ye[0] - ye[1]) + raw_dx[0] * (xe[0] - xe[1]);
  assign area_zero = (area_raw == '0);

`ifdef TRI_RASTER_CULL_EN
  assign cull_tri = area_raw[EDGE_W-1];
`else
  assign cull_tri = 1'b0;
`endif

  always_comb begin
    raw_minx = vx_reg[0];
    raw_maxx = vx_reg[0];
    raw_miny = vy_reg[0];
    raw_maxy = vy_reg[0];
    for (int i = 1; i < 3; i++) begin
      if (vx_reg[i] < raw_minx) raw_minx = vx_reg[i];
      if (vx_reg[i] > raw_maxx) raw_maxx = vx_reg[i];
      if (vy_reg[i] < raw_miny) raw_miny = vy_reg[i];
      if (vy_reg[i] > raw_maxy) raw_maxy = vy_reg[i];
    end
    bb_minx   = (raw_minx < 0) ? '0 : raw_minx;
    bb_miny   = (raw_miny < 0) ? '0 : raw_miny;
    bb_maxx   = (raw_maxx > MAX_X) ? MAX_X : raw_maxx;
    bb_maxy   = (raw_maxy > MAX_Y) ? MAX_Y : raw_maxy;
    box_empty = (bb_minx > bb_maxx) || (bb_miny > bb_maxy);
  end

  assign out_free  = !o_valid || i_ready;
  assign scan_go   = (state_reg == ST_SCAN) && out_free;
  assign row_end   = (x_reg == maxx_reg);
  assign last_cand = row_end && (y_reg == maxy_reg);
  assign covered   = &edge_pos;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (i_start) state_next = ST_SETUP0;
      ST_SETUP0: state_next = (area_zero || box_empty || cull_tri) ? ST_DONE : ST_SETUP1;
      ST_SETUP1: state_next = ST_SCAN;
      ST_SCAN:   if (scan_go && last_cand) state_next = ST_FLUSH;
      ST_FLUSH:  if (out_free) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg  <= ST_IDLE;
      for (int i = 0; i < 3; i++) begin
        vx_reg[i] <= '0;
        vy_reg[i] <= '0;
        dx_reg[i] <= '0;
        dy_reg[i] <= '0;
      end
      colour_reg <= '0;
      neg_reg    <= 1'b0;
      area_reg   <= '0;
      minx_reg   <= '0;
      maxx_reg   <= '0;
      miny_reg   <= '0;
      maxy_reg   <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      o_valid    <= 1'b0;
      o_x        <= '0;
      o_y        <= '0;
      o_w0       <= '0;
      o_w1       <= '0;
      o_w2       <= '0;
      o_area     <= '0;
      o_colour   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            vx_reg[0]  <= i_x1;
            vy_reg[0]  <= i_y1;
            vx_reg[1]  <= i_x2;
            vy_reg[1]  <= i_y2;
            vx_reg[2]  <= i_x3;
            vy_reg[2]  <= i_y3;
            colour_reg <= i_colour;
          end
        end
        ST_SETUP0: begin
          // Orientation is folded into the steps so the interior is always non-negative.
          neg_reg  <= area_raw[EDGE_W-1];
          area_reg <= area_raw[EDGE_W-1] ? -area_raw : area_raw;
          for (int i = 0; i < 3; i++) begin
            dx_reg[i] <= area_raw[EDGE_W-1] ? -raw_dx[i] : raw_dx[i];
            dy_reg[i] <= area_raw[EDGE_W-1] ? -raw_dy[i] : raw_dy[i];
          end
          minx_reg <= bb_minx;
          maxx_reg <= bb_maxx;
          miny_reg <= bb_miny;
          maxy_reg <= bb_maxy;
        end
        ST_SETUP1: begin
          x_reg <= minx_reg;
          y_reg <= miny_reg;
        end
        ST_SCAN: begin
          if (out_free) begin
            o_valid <= covered;
            if (covered) begin
              o_x      <= x_reg;
              o_y      <= y_reg;
              o_w0     <= cur_val[0];
              o_w1     <= cur_val[1];
              o_w2     <= cur_val[2];
              o_area   <= area_reg;
              o_colour <= colour_reg;
            end
            if (row_end) begin
              x_reg <= minx_reg;
              y_reg <= y_reg + COORD_W'(1);
            end else begin
              x_reg <= x_reg + COORD_W'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (i_ready) o_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_idle = (state_reg == ST_IDLE);
  assign o_done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_tri_raster_stream.sv
// Self-checking bench: constant vector table plus random triangles against a direct edge-function model.
module tb_tri_raster_stream;

  localparam int COORD_W  = 12;
  localparam int EDGE_W   = 2*COORD_W + 3;
  localparam int COLOUR_W = 32;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  logic i_clk = 1'b0;
  logic i_reset, i_start, i_ready;
  logic signed [COORD_W-1:0] i_x1, i_y1, i_x2, i_y2, i_x3, i_y3;
  logic [COLOUR_W-1:0] i_colour, o_colour;
  logic o_idle, o_valid, o_done;
  logic signed [COORD_W-1:0] o_x, o_y;
  logic signed [EDGE_W-1:0] o_w0, o_w1, o_w2, o_area;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  tri_raster_stream #(
    .COORD_W(COORD_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
    .COLOUR_W(COLOUR_W), .EDGE_W(EDGE_W)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_x1(i_x1), .i_y1(i_y1), .i_x2(i_x2), .i_y2(i_y2), .i_x3(i_x3), .i_y3(i_y3),
    .i_colour(i_colour), .o_idle(o_idle), .o_valid(o_valid), .i_ready(i_ready),
    .o_x(o_x), .o_y(o_y), .o_w0(o_w0), .o_w1(o_w1), .o_w2(o_w2),
    .o_area(o_area), .o_colour(o_colour), .o_done(o_done)
  );

  typedef struct packed {
    int x; int y; int w0; int w1; int w2; int area;
  } pix_t;

  typedef struct {
    int x1, y1, x2, y2, x3, y3;
    int mode;          // 0: ready high, 1: ready 1010..., 2: random ready
    int cnt;
    int fx, fy, fw0, fw1, fw2;
    int lx, ly, lw0, lw1, lw2;
    int area;
    int done_at;       // -1: don't check
  } vec_t;

  pix_t exp_q[$];

  function automatic int edge_fn(int xj, int yj, int xk, int yk, int px, int py);
    return (xk - xj) * (py - yj) - (yk - yj) * (px - xj);
  endfunction

  // Brute-force coverage over the clipped box, evaluated pixel by pixel.
  task automatic build_model(input int x1, y1, x2, y2, x3, y3);
    int a, s, lox, hix, loy, hiy, e0, e1, e2;
    exp_q.delete();
    a = edge_fn(x2, y2, x3, y3, x1, y1);
    s = (a < 0) ? -1 : 1;
`ifdef TRI_RASTER_CULL_EN
    if (a < 0) return;
`endif
    if (a == 0) return;
    lox = (x1 < x2) ? x1 : x2; lox = (x3 < lox) ? x3 : lox; if (lox < 0) lox = 0;
    loy = (y1 < y2) ? y1 : y2; loy = (y3 < loy) ? y3 : loy; if (loy < 0) loy = 0;
    hix = (x1 > x2) ? x1 : x2; hix = (x3 > hix) ? x3 : hix; if (hix > SCREEN_W-1) hix = SCREEN_W-1;
    hiy = (y1 > y2) ? y1 : y2; hiy = (y3 > hiy) ? y3 : hiy; if (hiy > SCREEN_H-1) hiy = SCREEN_H-1;
    for (int py = loy; py <= hiy; py++)
      for (int px = lox; px <= hix; px++) begin
        e0 = s * edge_fn(x2, y2, x3, y3, px, py);
        e1 = s * edge_fn(x3, y3, x1, y1, px, py);
        e2 = s * edge_fn(x1, y1, x2, y2, px, py);
        if (e0 >= 0 && e1 >= 0 && e2 >= 0) exp_q.push_back('{px, py, e0, e1, e2, s * a});
      end
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic run_tri(input string tag, input int x1, y1, x2, y2, x3, y3,
                         input int mode, input logic [COLOUR_W-1:0] col,
                         output int n_pix, output pix_t first_p, output pix_t last_p,
                         output int done_cyc);
    int k, last_acc;
    bit finished, stall_prev;
    pix_t held, cur, e;
    logic [COLOUR_W-1:0] held_col;
    build_model(x1, y1, x2, y2, x3, y3);
    n_pix = 0; done_cyc = -1; finished = 0; stall_prev = 0; k = 0; last_acc = -1;
    first_p = '0; last_p = '0; held = '0; held_col = '0;
    @(negedge i_clk);
    i_x1 = COORD_W'(x1); i_y1 = COORD_W'(y1);
    i_x2 = COORD_W'(x2); i_y2 = COORD_W'(y2);
    i_x3 = COORD_W'(x3); i_y3 = COORD_W'(y3);
    i_colour = col; i_start = 1'b1; i_ready = 1'b1;
    while (!finished && k < 5000) begin
      @(negedge i_clk);
      k++;
      i_start = 1'b0;
      cur = '{int'(o_x), int'(o_y), int'(o_w0), int'(o_w1), int'(o_w2), int'(o_area)};
      if (stall_prev) begin
        checks++;
        if (!o_valid || cur != held || o_colour !== held_col) begin
          errors++;
          $display("FAIL %s hold cycle %0d actual v=%0d x=%0d y=%0d w=%0d,%0d,%0d required v=1 x=%0d y=%0d w=%0d,%0d,%0d",
                   tag, k, o_valid, cur.x, cur.y, cur.w0, cur.w1, cur.w2,
                   held.x, held.y, held.w0, held.w1, held.w2);
        end
      end
      case (mode)
        0:       i_ready = 1'b1;
        1:       i_ready = k[0];
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
      if (o_done) begin
        finished = 1;
        done_cyc = k;
      end
      if (o_valid && i_ready) begin
        n_pix++;
        if (n_pix == 1) first_p = cur;
        last_p = cur;
        last_acc = k;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra pixel actual x=%0d y=%0d required none", tag, cur.x, cur.y);
        end else begin
          e = exp_q.pop_front();
          if (cur != e || o_colour !== col) begin
            errors++;
            $display("FAIL %s pixel %0d actual x=%0d y=%0d w=%0d,%0d,%0d a=%0d c=%h required x=%0d y=%0d w=%0d,%0d,%0d a=%0d c=%h",
                     tag, n_pix, cur.x, cur.y, cur.w0, cur.w1, cur.w2, cur.area, o_colour,
                     e.x, e.y, e.w0, e.w1, e.w2, e.area, col);
          end
        end
      end
      stall_prev = o_valid && !i_ready;
      held = cur;
      held_col = o_colour;
    end
    check({tag, "_done_seen"}, int'(finished), 1);
    check({tag, "_missing_pixels"}, exp_q.size(), 0);
    if (last_acc >= 0) check({tag, "_done_after_last"}, int'(done_cyc > last_acc), 1);
    @(negedge i_clk);
    i_ready = 1'b1;
    check({tag, "_done_one_cycle"}, int'(o_done), 0);
    check({tag, "_idle_after"}, int'(o_idle), 1);
  endtask

  vec_t vecs[7];

  initial begin
    int n, dc, k;
    bit seen;
    pix_t fp, lp;
    int bx, by;

    vecs[0] = '{0,0, 4,0, 0,4, 0, 15, 0,0,16,0,0, 0,4,0,0,16, 16, -1};
    vecs[1] = '{0,0, 4,0, 0,4, 1, 15, 0,0,16,0,0, 0,4,0,0,16, 16, -1};
`ifdef TRI_RASTER_CULL_EN
    vecs[2] = '{0,0, 0,4, 4,0, 0, 0, 0,0,0,0,0, 0,0,0,0,0, 0, 2};
`else
    vecs[2] = '{0,0, 0,4, 4,0, 0, 15, 0,0,16,0,0, 0,4,0,16,0, 16, -1};
`endif
    vecs[3] = '{0,0, 2,2, 4,4, 0, 0, 0,0,0,0,0, 0,0,0,0,0, 0, 2};
    vecs[4] = '{-5,-5, 9,-5, -5,9, 2, 15, 0,0,56,70,70, 0,4,0,70,126, 196, -1};
    vecs[5] = '{-5,-5, 3,-5, -5,3, 1, 0, 0,0,0,0,0, 0,0,0,0,0, 0, -1};
    vecs[6] = '{700,10, 720,10, 700,30, 0, 0, 0,0,0,0,0, 0,0,0,0,0, 0, 2};

    i_reset = 1'b1; i_start = 1'b0; i_ready = 1'b1; i_colour = '0;
    i_x1 = '0; i_y1 = '0; i_x2 = '0; i_y2 = '0; i_x3 = '0; i_y3 = '0;
    repeat (3) @(negedge i_clk);
    check("reset_idle", int'(o_idle), 1);
    check("reset_valid", int'(o_valid), 0);
    check("reset_done", int'(o_done), 0);
    check("reset_x", int'(o_x), 0);
    check("reset_area", int'(o_area), 0);
    check("reset_colour", int'(o_colour), 0);
    i_reset = 1'b0;
    @(negedge i_clk);

    for (int i = 0; i < 7; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      run_tri(t, vecs[i].x1, vecs[i].y1, vecs[i].x2, vecs[i].y2, vecs[i].x3, vecs[i].y3,
              vecs[i].mode, 32'hC0DE_0000 + i, n, fp, lp, dc);
      $display("vec %0d: pixels=%0d done_cycle=%0d", i, n, dc);
      check({t, "_count"}, n, vecs[i].cnt);
      if (vecs[i].cnt > 0) begin
        check({t, "_first_x"}, fp.x, vecs[i].fx);
        check({t, "_first_y"}, fp.y, vecs[i].fy);
        check({t, "_first_w0"}, fp.w0, vecs[i].fw0);
        check({t, "_first_w1"}, fp.w1, vecs[i].fw1);
        check({t, "_first_w2"}, fp.w2, vecs[i].fw2);
        check({t, "_last_x"}, lp.x, vecs[i].lx);
        check({t, "_last_y"}, lp.y, vecs[i].ly);
        check({t, "_last_w0"}, lp.w0, vecs[i].lw0);
        check({t, "_last_w1"}, lp.w1, vecs[i].lw1);
        check({t, "_last_w2"}, lp.w2, vecs[i].lw2);
        check({t, "_area"}, fp.area, vecs[i].area);
      end
      if (vecs[i].done_at >= 0) check({t, "_done_latency"}, dc, vecs[i].done_at);
    end

    for (int i = 0; i < 12; i++) begin
      string t;
      t = $sformatf("rnd%0d", i);
      bx = ($urandom_range(0, 2) == 0) ? 620 : 0;
      by = ($urandom_range(0, 2) == 0) ? 460 : 0;
      run_tri(t, bx + int'($urandom_range(0, 30)) - 6, by + int'($urandom_range(0, 30)) - 6,
                 bx + int'($urandom_range(0, 30)) - 6, by + int'($urandom_range(0, 30)) - 6,
                 bx + int'($urandom_range(0, 30)) - 6, by + int'($urandom_range(0, 30)) - 6,
              2, $urandom, n, fp, lp, dc);
      $display("rnd %0d: pixels=%0d done_cycle=%0d", i, n, dc);
    end

    // Reset while a pixel is stalled at the output.
    @(negedge i_clk);
    i_x1 = 0; i_y1 = 0; i_x2 = 4; i_y2 = 0; i_x3 = 0; i_y3 = 4;
    i_colour = 32'h1234_5678; i_start = 1'b1; i_ready = 1'b0;
    k = 0;
    do begin
      @(negedge i_clk);
      i_start = 1'b0;
      k++;
    end while (!o_valid && k < 20);
    check("rst_pre_valid", int'(o_valid), 1);
    #2 i_reset = 1'b1;
    #1;
    check("rst_valid_drop", int'(o_valid), 0);
    check("rst_idle", int'(o_idle), 1);
    check("rst_no_done_now", int'(o_done), 0);
    @(negedge i_clk);
    i_reset = 1'b0;
    i_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge i_clk);
      if (o_done || o_valid) seen = 1;
    end
    check("rst_quiet_after", int'(seen), 0);
    check("rst_idle_after", int'(o_idle), 1);
    run_tri("post_reset", 0, 0, 4, 0, 0, 4, 0, 32'hABCD_EF01, n, fp, lp, dc);
    $display("post reset: pixels=%0d done_cycle=%0d", n, dc);
    check("post_reset_count", n, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
